// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one external binary-to-BCD converter among N_REQ requesters.
// Operands saturate to 9999; results land in per-requester holding registers with a one-cycle ack.
module bcd_conv_arbiter #(
  parameter int unsigned N_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   bin_flat,
  output logic [N_REQ-1:0]      ack,
  output logic [16*N_REQ-1:0]   bcd_flat,
  output logic [N_REQ-1:0]      ovf,
  output logic                  busy,
  output logic [15:0]           conv_bin,
  input  logic [15:0]           conv_bcd
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] MaxBin = 16'd9999;

  typedef enum logic [1:0] {StIdle, StConv, StCapt} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      g_q, g_d;
  logic                 sat_q, sat_d;
  logic [15:0]          conv_bin_q, conv_bin_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ-1:0]     ovf_q, ovf_d;
  logic [16*N_REQ-1:0]  bcd_q, bcd_d;

  logic [N_REQ-1:0]     elig;
  logic                 grant_vld;
  logic [IdxW-1:0]      grant_idx;
  logic [IdxW-1:0]      cand_idx;
  int unsigned          cand;
  logic [15:0]          grant_bin;

  // A requester still seeing its ack is masked so a late req drop cannot re-grant it.
  assign elig = req & ~ack_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IdxW-1:0];
      if (!grant_vld && elig[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign grant_bin = bin_flat[16*grant_idx +: 16];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    sat_d      = sat_q;
    conv_bin_d = conv_bin_q;
    ack_d      = '0;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    case (state_q)
      StIdle: begin
        if (grant_vld) begin
          g_d   = grant_idx;
          ptr_d = grant_idx;
          if (grant_bin > MaxBin) begin
            conv_bin_d = MaxBin;
            sat_d      = 1'b1;
          end else begin
            conv_bin_d = grant_bin;
            sat_d      = 1'b0;
          end
          state_d = StConv;
        end
      end
      StConv: state_d = StCapt;
      StCapt: begin
        bcd_d[16*g_q +: 16] = conv_bcd;
        ovf_d[g_q]          = sat_q;
        ack_d[g_q]          = 1'b1;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IdxW'(N_REQ - 1);
      g_q        <= '0;
      sat_q      <= 1'b0;
      conv_bin_q <= '0;
      ack_q      <= '0;
      ovf_q      <= '0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      sat_q      <= sat_d;
      conv_bin_q <= conv_bin_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign ack      = ack_q;
  assign ovf      = ovf_q;
  assign bcd_flat = bcd_q;
  assign conv_bin = conv_bin_q;
  assign busy     = (state_q != StIdle);

endmodule
